// File: rtl/keypad_scan_ctrl.sv
// Matrix keypad scanner: one-hot row drive, frame-level debounce, priority resolve, key events.
// Optional typematic repeat is compiled in when KEYPAD_REPEAT_EN is defined.
module keypad_scan_ctrl #(
    parameter int ROWS           = 4,
    parameter int COLS           = 3,
    parameter int SCAN_DIV       = 8,
    parameter int DEBOUNCE_SCANS = 3,
    parameter int REPEAT_DELAY   = 8,
    parameter int REPEAT_RATE    = 2,
    localparam int KW            = $clog2(ROWS * COLS)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic [COLS-1:0] col_i,
    output logic [ROWS-1:0] row_o,
    output logic [KW-1:0]   key_code_o,
    output logic            key_valid_o,
    output logic            key_held_o
);

    localparam int CW = $clog2(COLS);
    localparam int RW = $clog2(ROWS);
    localparam int DW = $clog2(SCAN_DIV);

    generate
        if (SCAN_DIV < 4) begin : g_bad_div
            $error("keypad_scan_ctrl: SCAN_DIV must be at least 4");
        end
        if (ROWS * COLS < 2 || ROWS < 2 || COLS < 2 || ROWS > 8 || COLS > 8) begin : g_bad_dim
            $error("keypad_scan_ctrl: ROWS and COLS must each be in 2..8");
        end
        if (DEBOUNCE_SCANS < 1 || DEBOUNCE_SCANS > 15) begin : g_bad_deb
            $error("keypad_scan_ctrl: DEBOUNCE_SCANS must be in 1..15");
        end
        if (REPEAT_RATE < 1 || REPEAT_RATE > REPEAT_DELAY) begin : g_bad_rpt
            $error("keypad_scan_ctrl: need 1 <= REPEAT_RATE <= REPEAT_DELAY");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, DEB_PRESS, HELD} state_t;

    logic [COLS-1:0] col_meta_q, col_sync_q;
    logic [DW-1:0]   dwell_q, dwell_d;
    logic [RW-1:0]   ridx_q, ridx_d;
    logic [ROWS-1:0] row_q, row_d;
    logic            sample, last_row;

    logic            col_hit;
    logic [CW-1:0]   col_sel;
    logic [KW-1:0]   row_key;
    logic            frame_hit;
    logic [KW-1:0]   frame_key;
    logic            found_q;
    logic [KW-1:0]   fidx_q;
    logic            commit_q, res_hit_q;
    logic [KW-1:0]   res_q;

    state_t          state_q;
    logic [KW-1:0]   cand_q;
    logic [3:0]      cnt_q, rcnt_q;
    logic [KW-1:0]   key_code_q;
    logic            key_valid_q, key_held_q;
    logic            res_match, accept;

`ifdef KEYPAD_REPEAT_EN
    localparam int RPW = $clog2(REPEAT_DELAY + 1);
    logic [RPW-1:0]  rpt_q;
`endif

    // Two-flop synchroniser; columns are asynchronous to the scan clock.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            col_meta_q <= '0;
            col_sync_q <= '0;
        end else begin
            col_meta_q <= col_i;
            col_sync_q <= col_meta_q;
        end
    end

    assign sample   = (dwell_q == DW'(SCAN_DIV - 1));
    assign last_row = (ridx_q == RW'(ROWS - 1));

    always_comb begin
        dwell_d = dwell_q + 1'b1;
        ridx_d  = ridx_q;
        row_d   = row_q;
        if (sample) begin
            dwell_d = '0;
            ridx_d  = last_row ? '0 : ridx_q + 1'b1;
            row_d   = {row_q[ROWS-2:0], row_q[ROWS-1]};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            dwell_q <= '0;
            ridx_q  <= '0;
            row_q   <= ROWS'(1);
        end else begin
            dwell_q <= dwell_d;
            ridx_q  <= ridx_d;
            row_q   <= row_d;
        end
    end

    // Lowest active column wins within a row.
    always_comb begin
        col_hit = 1'b0;
        col_sel = '0;
        for (int c = COLS - 1; c >= 0; c--) begin
            if (col_sync_q[c]) begin
                col_hit = 1'b1;
                col_sel = CW'(c);
            end
        end
    end

    assign row_key   = KW'(ridx_q) * KW'(COLS) + KW'(col_sel);
    assign frame_hit = found_q | col_hit;
    assign frame_key = found_q ? fidx_q : row_key;

    // Earlier rows take priority, so the first hit of a frame is kept.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            found_q   <= 1'b0;
            fidx_q    <= '0;
            commit_q  <= 1'b0;
            res_hit_q <= 1'b0;
            res_q     <= '0;
        end else begin
            commit_q <= 1'b0;
            if (sample) begin
                if (last_row) begin
                    commit_q  <= 1'b1;
                    res_hit_q <= frame_hit;
                    res_q     <= frame_hit ? frame_key : '0;
                    found_q   <= 1'b0;
                    fidx_q    <= '0;
                end else begin
                    found_q <= frame_hit;
                    fidx_q  <= frame_key;
                end
            end
        end
    end

    assign res_match = res_hit_q && (res_q == cand_q);
    assign accept    = commit_q &&
                       ((state_q == IDLE && res_hit_q && (DEBOUNCE_SCANS == 1)) ||
                        (state_q == DEB_PRESS && res_match &&
                         (cnt_q + 4'd1 == 4'(DEBOUNCE_SCANS))));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            cand_q      <= '0;
            cnt_q       <= '0;
            rcnt_q      <= '0;
            key_code_q  <= '0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            rpt_q       <= '0;
`endif
        end else begin
            key_valid_q <= 1'b0;
            if (accept) begin
                state_q     <= HELD;
                cand_q      <= res_q;
                key_code_q  <= res_q;
                key_valid_q <= 1'b1;
                key_held_q  <= 1'b1;
                cnt_q       <= '0;
                rcnt_q      <= '0;
`ifdef KEYPAD_REPEAT_EN
                rpt_q       <= '0;
`endif
            end else if (commit_q) begin
                case (state_q)
                    IDLE: begin
                        if (res_hit_q) begin
                            cand_q  <= res_q;
                            cnt_q   <= 4'd1;
                            state_q <= DEB_PRESS;
                        end
                    end
                    DEB_PRESS: begin
                        if (!res_hit_q) begin
                            cnt_q   <= '0;
                            state_q <= IDLE;
                        end else if (res_match) begin
                            cnt_q <= cnt_q + 4'd1;
                        end else begin
                            cand_q <= res_q;
                            cnt_q  <= 4'd1;
                        end
                    end
                    HELD: begin
                        // Any frame other than the held key, including a new key, counts toward release.
                        if (res_match) begin
                            rcnt_q <= '0;
`ifdef KEYPAD_REPEAT_EN
                            if (rpt_q + 1'b1 == RPW'(REPEAT_DELAY)) begin
                                key_valid_q <= 1'b1;
                                rpt_q       <= RPW'(REPEAT_DELAY - REPEAT_RATE);
                            end else begin
                                rpt_q <= rpt_q + 1'b1;
                            end
`endif
                        end else if (rcnt_q + 4'd1 == 4'(DEBOUNCE_SCANS)) begin
                            rcnt_q     <= '0;
                            key_held_q <= 1'b0;
                            state_q    <= IDLE;
                        end else begin
                            rcnt_q <= rcnt_q + 4'd1;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign row_o       = row_q;
    assign key_code_o  = key_code_q;
    assign key_valid_o = key_valid_q;
    assign key_held_o  = key_held_q;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Scoreboard bench for keypad_scan_ctrl at default parameters (frame = 32 cycles).
// Expected key events are queued with their cycle; a negedge monitor pops and compares.
module tb_keypad_scan_ctrl;
    localparam int ROWS = 4;
    localparam int COLS = 3;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [COLS-1:0]   col;
    logic [ROWS-1:0]   row;
    logic [3:0]        key_code;
    logic              key_valid;
    logic              key_held;
    logic [ROWS*COLS-1:0] keys = '0;
    int                cyc;
    int                vectors = 0;
    int                miscompares = 0;

    typedef struct {int code; int cyc;} exp_t;
    exp_t sb[$];

    keypad_scan_ctrl dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .col_i       (col),
        .row_o       (row),
        .key_code_o  (key_code),
        .key_valid_o (key_valid),
        .key_held_o  (key_held)
    );

    always #5 clk = ~clk;

    // Keypad model: a pressed key shorts its row drive onto its column.
    always_comb begin
        col = '0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                if (row[r] && keys[r*COLS+c]) col[c] = 1'b1;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && key_valid) begin
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_pulse: code %0d at cycle %0d, no pulse required", key_code, cyc);
            end else begin
                e = sb.pop_front();
                if (key_code !== 4'(e.code) || cyc != e.cyc) begin
                    miscompares++;
                    $display("FAIL key_event: code %0d at cycle %0d, required code %0d at cycle %0d",
                             key_code, cyc, e.code, e.cyc);
                end
            end
        end
    end

    task automatic push(input int code, input int at);
        exp_t e;
        e.code = code;
        e.cyc  = at;
        sb.push_back(e);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic at_cyc(input int n);
        int guard = 0;
        while (cyc < n && guard < 20000) begin
            @(negedge clk);
            guard++;
        end
        if (cyc < n) begin
            miscompares++;
            $display("FAIL timeout: waiting for cycle %0d, stuck at %0d", n, cyc);
        end
    endtask

    task automatic drain(input string name);
        exp_t e;
        while (sb.size() != 0) begin
            e = sb.pop_front();
            vectors++;
            miscompares++;
            $display("FAIL %s missing_pulse: required code %0d at cycle %0d", name, e.code, e.cyc);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        keys  = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        // Reset state and scan rotation
        do_reset();
        chk("rst_row",   32'(row), 1);
        chk("rst_code",  32'(key_code), 0);
        chk("rst_valid", 32'(key_valid), 0);
        chk("rst_held",  32'(key_held), 0);
        at_cyc(7);  chk("row_c7",  32'(row), 1);
        at_cyc(8);  chk("row_c8",  32'(row), 2);
        at_cyc(16); chk("row_c16", 32'(row), 4);
        at_cyc(24); chk("row_c24", 32'(row), 8);
        at_cyc(32); chk("row_c32", 32'(row), 1);

        // Clean press of (2,1) in frames 1..6: accepted on frame 3 commit (cycle 128)
        keys[7] = 1'b1;
        push(7, 129);
        at_cyc(200); chk("clean_held", 32'(key_held), 1);
        chk("clean_code", 32'(key_code), 7);
        at_cyc(224); keys = '0;
        at_cyc(320); chk("clean_held_edge", 32'(key_held), 1);
        at_cyc(321); chk("clean_released", 32'(key_held), 0);
        chk("clean_code_kept", 32'(key_code), 7);
        drain("clean");

        // Bounce on (0,2): present, absent, then stable from frame 3
        do_reset();
        at_cyc(32); keys[2] = 1'b1;
        at_cyc(64); keys = '0;
        at_cyc(96); keys[2] = 1'b1;
        push(2, 193);
        at_cyc(170); chk("bounce_not_yet", 32'(key_held), 0);
        at_cyc(200); chk("bounce_held", 32'(key_held), 1);
        chk("bounce_code", 32'(key_code), 2);
        at_cyc(224); keys = '0;
        at_cyc(330); drain("bounce");

        // Simultaneous (1,2) and (3,1): lower index 5 wins
        do_reset();
        at_cyc(32); keys[5] = 1'b1; keys[10] = 1'b1;
        push(5, 129);
        at_cyc(200); chk("multi_code", 32'(key_code), 5);
        chk("multi_held", 32'(key_held), 1);
        at_cyc(224); keys = '0;
        at_cyc(330); drain("multi");

        // Release debounce: 2-frame gap is absorbed, 3-frame gap releases, re-press reports again
        do_reset();
        at_cyc(32);  keys[7] = 1'b1;
        push(7, 129);
        at_cyc(160); keys = '0;
        at_cyc(224); keys[7] = 1'b1;
        at_cyc(230); chk("gap2_held", 32'(key_held), 1);
        at_cyc(320); keys = '0;
        at_cyc(416); chk("gap3_held_edge", 32'(key_held), 1);
        keys[7] = 1'b1;
        push(7, 513);
        at_cyc(417); chk("gap3_released", 32'(key_held), 0);
        chk("gap3_code_kept", 32'(key_code), 7);
        at_cyc(520); chk("repress_held", 32'(key_held), 1);
        at_cyc(544); keys = '0;
        at_cyc(650); drain("release");

        // Reset during a press debounce of key 7 while code 4 is latched
        do_reset();
        at_cyc(32);  keys[4] = 1'b1;
        push(4, 129);
        at_cyc(128); keys = '0;
        at_cyc(224); keys[7] = 1'b1;
        at_cyc(230); chk("pre_rst_held", 32'(key_held), 0);
        chk("pre_rst_code", 32'(key_code), 4);
        at_cyc(300);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_code",  32'(key_code), 0);
        chk("mid_rst_held",  32'(key_held), 0);
        chk("mid_rst_valid", 32'(key_valid), 0);
        chk("mid_rst_row",   32'(row), 1);
        keys = '0;
        @(negedge clk);
        rst_n = 1'b1;
        at_cyc(160);
        chk("post_rst_held", 32'(key_held), 0);
        drain("mid_reset");

`ifdef KEYPAD_REPEAT_EN
        // Typematic: accept at frame 3, repeats 8 frames later then every 2
        do_reset();
        at_cyc(32); keys[7] = 1'b1;
        push(7, 129); push(7, 385); push(7, 449); push(7, 513); push(7, 577);
        at_cyc(576); keys = '0;
        at_cyc(700); chk("rpt_released", 32'(key_held), 0);
        drain("repeat");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
